pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 6 +
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl_fwd_unit.sv | 14 +
 rtl/pipe_ctrl.sv | 74 +++++++
 tb/tb_pipe_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM type, forwarding selects and default timeout for pipe_ctrl
package pipe_ctrl_pkg;
   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
   localparam logic [1:0] FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
   localparam int DEF_MEM_TIMEOUT = 15;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline stage status in, register enables/flushes/forwarding/dmem handshake out
// master: core side (drives stage fields and dmem_ready, receives controls)
// slave: pipe_ctrl side; PIPE_CTRL_PERF_EN adds perf_stall/perf_flush
interface pipe_ctrl_if;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rf, mem_rf, wb_rf;
   logic       id_uses_rt, ex_regwr, ex_memrd, mem_regwr, mem_memrd, mem_memwr, wb_regwr, dmem_ready;
   logic [1:0] ex_pcsrc, fwd_a, fwd_b;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, memwb_flush, dmem_req, mem_err;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall, perf_flush;
`endif
   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rf, ex_regwr, ex_memrd, ex_pcsrc,
             mem_rf, mem_regwr, mem_memrd, mem_memwr, wb_rf, wb_regwr, dmem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush,
             fwd_a, fwd_b, dmem_req, mem_err
`ifdef PIPE_CTRL_PERF_EN
      , input perf_stall, perf_flush
`endif
   );
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rf, ex_regwr, ex_memrd, ex_pcsrc,
             mem_rf, mem_regwr, mem_memrd, mem_memwr, wb_rf, wb_regwr, dmem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush,
             fwd_a, fwd_b, dmem_req, mem_err
`ifdef PIPE_CTRL_PERF_EN
      , output perf_stall, perf_flush
`endif
   );
endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// fwd_unit: picks the EX operand source for one source register (MEM beats WB, r0 never forwarded)
// src_i: EX source reg; mem_*/wb_*: destination reg and write flag of later stages; sel_o: FWD_* select
module fwd_unit import pipe_ctrl_pkg::*; (
   input  logic [4:0] src_i,
   input  logic [4:0] mem_rf_i,
   input  logic       mem_regwr_i,
   input  logic [4:0] wb_rf_i,
   input  logic       wb_regwr_i,
   output logic [1:0] sel_o
);
   always_comb
      sel_o = (mem_regwr_i && mem_rf_i != 5'd0 && mem_rf_i == src_i) ? FWD_MEM :
              (wb_regwr_i && wb_rf_i != 5'd0 && wb_rf_i == src_i) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage hazard controller (load-use stall, redirect flush, forwarding, dmem wait/timeout)
// clk, reset (sync, active-high); bus: pipe_ctrl_if.slave carrying stage info in and controls out
// Optional PIPE_CTRL_PERF_EN: saturating stall/redirect cycle counters on bus.perf_stall/perf_flush
module pipe_ctrl import pipe_ctrl_pkg::*; #(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int TO_W        = 8
) (
   input logic        clk,
   input logic        reset,
   pipe_ctrl_if.slave bus
);
   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            mem_acc, freeze, redirect, load_use, stall_lu, to_hit;
   logic [1:0]      fa, fb;
   assign mem_acc  = bus.mem_memrd | bus.mem_memwr;
   // the cycle after a timeout the stuck access is still in MEM; err_q drops it instead of re-freezing
   assign freeze   = mem_acc & ~bus.dmem_ready & ~err_q & (cnt_q < TO_W'(MEM_TIMEOUT));
   assign redirect = bus.ex_pcsrc != 2'b00;
   assign load_use = bus.ex_memrd & bus.ex_regwr & (bus.ex_rf != 5'd0) &
                     ((bus.ex_rf == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rf == bus.id_rt)));
   assign stall_lu = ~freeze & ~redirect & load_use;
   assign to_hit   = cnt_q == TO_W'(MEM_TIMEOUT - 1);
   fwd_unit u_fwd_a (.src_i(bus.ex_rs), .mem_rf_i(bus.mem_rf), .mem_regwr_i(bus.mem_regwr),
                     .wb_rf_i(bus.wb_rf), .wb_regwr_i(bus.wb_regwr), .sel_o(fa));
   fwd_unit u_fwd_b (.src_i(bus.ex_rt), .mem_rf_i(bus.mem_rf), .mem_regwr_i(bus.mem_regwr),
                     .wb_rf_i(bus.wb_rf), .wb_regwr_i(bus.wb_regwr), .sel_o(fb));
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end
   // counter holds the number of completed MEM_WAIT cycles of the current access
   always_comb begin
      err_d   = (state_q == MEM_WAIT) & freeze & to_hit;
      state_d = (freeze & ~err_d) ? MEM_WAIT : RUN;
      cnt_d   = (state_q == MEM_WAIT && state_d == MEM_WAIT) ? cnt_q + 1'b1 : '0;
   end
   always_comb begin
      bus.pc_en       = ~reset & ~freeze & ~stall_lu;
      bus.ifid_en     = ~reset & ~freeze & ~stall_lu;
      bus.idex_en     = ~reset & ~freeze;
      bus.exmem_en    = ~reset & ~freeze;
      bus.memwb_en    = ~reset;
      bus.ifid_flush  = reset | (~freeze & redirect);
      bus.idex_flush  = reset | (~freeze & (redirect | load_use));
      bus.memwb_flush = reset | freeze | err_q;
      bus.dmem_req    = ~reset & mem_acc & ~err_q;
      bus.mem_err     = ~reset & err_q;
      bus.fwd_a       = reset ? FWD_RF : fa;
      bus.fwd_b       = reset ? FWD_RF : fb;
   end
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if ((freeze | stall_lu) && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
         if (~freeze & redirect && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end
   assign bus.perf_stall = perf_stall_q;
   assign bus.perf_flush = perf_flush_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus for pipe_ctrl checked against a behavioural model
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;
   localparam int TO = 15;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0, miscompares = 0, err_pulses = 0;
   int   stall_k = 0;
   bit   m_err = 1'b0;
   pipe_ctrl_if bus();
   pipe_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [1:0] fsel(logic [4:0] src);
      if (bus.mem_regwr && bus.mem_rf != 5'd0 && bus.mem_rf == src) return 2'b01;
      if (bus.wb_regwr && bus.wb_rf != 5'd0 && bus.wb_rf == src) return 2'b10;
      return 2'b00;
   endfunction
   task automatic clr();
      {bus.id_rs, bus.id_rt, bus.ex_rs, bus.ex_rt, bus.ex_rf, bus.mem_rf, bus.wb_rf} = '0;
      {bus.id_uses_rt, bus.ex_regwr, bus.ex_memrd, bus.mem_regwr, bus.mem_memrd, bus.mem_memwr} = '0;
      {bus.wb_regwr, bus.dmem_ready} = '0;
      bus.ex_pcsrc = 2'b00;
   endtask
   task automatic rnd(int ready_pct);
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_rs = 5'($urandom_range(0, 3));
      bus.ex_rt = 5'($urandom_range(0, 3));
      bus.ex_rf = 5'($urandom_range(0, 3));
      bus.mem_rf = 5'($urandom_range(0, 3));
      bus.wb_rf = 5'($urandom_range(0, 3));
      bus.id_uses_rt = 1'($urandom_range(0, 1));
      bus.ex_regwr = 1'($urandom_range(0, 1));
      bus.ex_memrd = 1'($urandom_range(0, 1));
      bus.mem_regwr = 1'($urandom_range(0, 1));
      bus.wb_regwr = 1'($urandom_range(0, 1));
      bus.mem_memrd = $urandom_range(0, 3) == 0;
      bus.mem_memwr = $urandom_range(0, 5) == 0;
      bus.dmem_ready = $urandom_range(0, 99) < ready_pct;
      bus.ex_pcsrc = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
   endtask
   // one clock: inputs already driven after the falling edge, outputs checked mid-low-phase
   task automatic cyc();
      bit acc, frz, redir, lu, lus;
      logic [4:0] en;
      logic [2:0] fl;
      #2;
      acc   = bus.mem_memrd | bus.mem_memwr;
      frz   = acc && !bus.dmem_ready && !m_err && stall_k <= TO;
      redir = bus.ex_pcsrc != 2'b00;
      lu    = bus.ex_memrd && bus.ex_regwr && bus.ex_rf != 5'd0 &&
              (bus.ex_rf == bus.id_rs || (bus.id_uses_rt && bus.ex_rf == bus.id_rt));
      lus   = !frz && !redir && lu;
      if (reset) begin
         en = 5'b00000;
         fl = 3'b111;
      end else begin
         en = {!frz && !lus, !frz && !lus, !frz, !frz, 1'b1};
         fl = {!frz && redir, !frz && (redir || lu), frz || m_err};
      end
      chk("enables", 8'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}), 8'(en));
      chk("flushes", 8'({bus.ifid_flush, bus.idex_flush, bus.memwb_flush}), 8'(fl));
      chk("fwd_a", 8'(bus.fwd_a), reset ? 8'd0 : 8'(fsel(bus.ex_rs)));
      chk("fwd_b", 8'(bus.fwd_b), reset ? 8'd0 : 8'(fsel(bus.ex_rt)));
      chk("dmem_req", 8'(bus.dmem_req), 8'(!reset && acc && !m_err));
      chk("mem_err", 8'(bus.mem_err), 8'(!reset && m_err));
      if (bus.mem_err) err_pulses++;
      @(posedge clk);
      if (reset) begin
         stall_k = 0;
         m_err = 1'b0;
      end else begin
         m_err = frz && stall_k == TO;
         stall_k = (frz && !m_err) ? stall_k + 1 : 0;
      end
      @(negedge clk);
   endtask
   initial begin
      clr();
      reset = 1'b1;
      @(negedge clk);
      bus.mem_memrd = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      clr();
      cyc();
      bus.ex_memrd = 1'b1; bus.ex_regwr = 1'b1; bus.ex_rf = 5'd5; bus.id_rs = 5'd5;
      cyc();
      bus.ex_memrd = 1'b0; bus.ex_regwr = 1'b0; bus.mem_memrd = 1'b1; bus.mem_regwr = 1'b1;
      bus.mem_rf = 5'd5; bus.dmem_ready = 1'b1;
      cyc();
      clr();
      bus.ex_memrd = 1'b1; bus.ex_regwr = 1'b1; bus.ex_rf = 5'd0;
      cyc();
      clr();
      bus.ex_memrd = 1'b1; bus.ex_regwr = 1'b1; bus.ex_rf = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
      cyc();
      clr();
      bus.mem_rf = 5'd3; bus.wb_rf = 5'd3; bus.mem_regwr = 1'b1; bus.wb_regwr = 1'b1; bus.ex_rs = 5'd3;
      cyc();
      chk("fwd_a_mem_wins", 8'(bus.fwd_a), 8'(FWD_MEM));
      bus.mem_regwr = 1'b0; bus.ex_rt = 5'd3;
      cyc();
      bus.ex_rs = 5'd0; bus.ex_rt = 5'd0; bus.mem_rf = 5'd0; bus.wb_rf = 5'd0; bus.mem_regwr = 1'b1;
      cyc();
      clr();
      bus.mem_memrd = 1'b1;
      repeat (4) cyc();
      bus.dmem_ready = 1'b1;
      cyc();
      clr();
      bus.mem_memwr = 1'b1; bus.dmem_ready = 1'b1;
      cyc();
      clr();
      err_pulses = 0;
      bus.mem_memrd = 1'b1;
      repeat (17) cyc();
      chk("err_pulses_timeout", 8'(err_pulses), 8'd1);
      bus.mem_memrd = 1'b0;
      cyc();
      clr();
      bus.ex_pcsrc = 2'b01;
      bus.ex_memrd = 1'b1; bus.ex_regwr = 1'b1; bus.ex_rf = 5'd4; bus.id_rs = 5'd4;
      cyc();
      clr();
      bus.ex_pcsrc = 2'b10; bus.mem_memrd = 1'b1;
      repeat (2) cyc();
      bus.dmem_ready = 1'b1;
      cyc();
      clr();
      err_pulses = 0;
      bus.mem_memrd = 1'b1;
      repeat (2) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #2;
      chk("state_after_reset", 8'(dut.state_q), 8'(RUN));
      chk("cnt_after_reset", 8'(dut.cnt_q), 8'd0);
      repeat (3) cyc();
      chk("err_pulses_reset", 8'(err_pulses), 8'd0);
      clr();
      cyc();
      repeat (1500) begin
         rnd(20);
         reset = $urandom_range(0, 199) == 0;
         cyc();
      end
      repeat (1500) begin
         rnd(70);
         reset = $urandom_range(0, 199) == 0;
         cyc();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
